// File: rtl/param_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : param_cmd_decoder
// Description : Command packet decoder for an edge-PE accelerator. Routes
//               task packets to the reservation station or to memory,
//               handles replay barriers, and latches stream configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module param_cmd_decoder #(
   parameter int PKT_W    = 32,
   parameter int NUM_PE   = 4,
   parameter int MAX_ITER = 4,
   parameter int MASK_LO  = 10,
   parameter int FV_W     = 5,
   parameter int WB_W     = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_valid,
   input  logic [PKT_W-1:0]            cmd_packet,
   output logic                        cmd_ready,
   output logic                        rs_valid,
   output logic [PKT_W-3:0]            rs_packet,
   input  logic                        rs_ready,
   input  logic                        rs_empty,
   input  logic [NUM_PE-1:0]           bank_busy,
   input  logic [NUM_PE-1:0]           pe_idle,
   output logic                        mem_req,
   input  logic                        mem_grant,
   output logic                        mem_valid,
   output logic [PKT_W-1:0]            mem_packet,
   input  logic                        stream_end,
   input  logic                        vertex_done,
   output logic                        stream_begin,
   output logic                        replay_flag,
   output logic [$clog2(MAX_ITER)-1:0] replay_iter,
   output logic [FV_W-1:0]             num_fv,
   output logic [WB_W-1:0]             weights_boundary,
   output logic                        cntl_done,
   output logic                        task_complete
);

   localparam int c_IT_W  = $clog2(MAX_ITER);
   localparam int c_PKT_AW = $clog2(PKT_W);

   localparam logic [1:0] c_OP_TASK    = 2'b00;
   localparam logic [1:0] c_OP_BARRIER = 2'b01;
   localparam logic [1:0] c_OP_NUM_FV  = 2'b10;
   localparam logic [1:0] c_OP_WB      = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_WAIT_RS     = 3'd1,
      S_WAIT_GRANT  = 3'd2,
      S_WAIT_DRAIN  = 3'd3,
      S_WAIT_STREAM = 3'd4,
      S_WAIT_DONE   = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_live;
   logic [PKT_W-1:0]    r_pkt;
   logic [c_IT_W-1:0]   r_iter;
   logic                r_flag;
   logic [FV_W-1:0]     r_num_fv;
   logic [WB_W-1:0]     r_wb;
   logic                r_stream_begin;

   logic                w_accept;
   logic [1:0]          w_opcode;
   logic [c_PKT_AW-1:0] w_mask_idx;
   logic                w_mask_bit;
   logic                w_drained;
   logic                w_last;
   logic                w_iter_inc;
   logic                w_iter_clr;
   logic                w_flag_set;
   logic                w_flag_clr;

   // r_live holds cmd_ready low until the first clock edge after reset release
   assign cmd_ready  = (r_state == S_IDLE) && r_live;
   assign w_accept   = cmd_valid && cmd_ready;
   assign w_opcode   = cmd_packet[PKT_W-1:PKT_W-2];
   // Mask bit selected by the iteration the task is issued under
   assign w_mask_idx = c_PKT_AW'(MASK_LO) + c_PKT_AW'(r_iter);
   assign w_mask_bit = cmd_packet[w_mask_idx];
   assign w_drained  = (bank_busy == '0) && rs_empty && (&pe_idle);
   assign w_last     = (r_iter == c_IT_W'(MAX_ITER - 1));

   assign rs_packet        = rs_valid  ? r_pkt[PKT_W-3:0] : '0;
   assign mem_packet       = mem_valid ? r_pkt : '0;
   assign replay_iter      = r_iter;
   assign replay_flag      = r_flag;
   assign num_fv           = r_num_fv;
   assign weights_boundary = r_wb;
   assign stream_begin     = r_stream_begin;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and per-state outputs; each pulse belongs to a single state
   always_comb begin
      w_next        = r_state;
      rs_valid      = 1'b0;
      mem_req       = 1'b0;
      mem_valid     = 1'b0;
      cntl_done     = 1'b0;
      task_complete = 1'b0;
      w_iter_inc    = 1'b0;
      w_iter_clr    = 1'b0;
      w_flag_set    = 1'b0;
      w_flag_clr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_opcode == c_OP_TASK) begin
                  w_next = w_mask_bit ? S_WAIT_RS : S_WAIT_GRANT;
               end else if (w_opcode == c_OP_BARRIER) begin
                  w_next = S_WAIT_DRAIN;
               end else if (w_opcode == c_OP_WB) begin
                  w_next = S_WAIT_STREAM;
               end
            end
         end
         S_WAIT_RS: begin
            rs_valid = 1'b1;
            if (rs_ready) begin
               w_next = S_IDLE;
            end
         end
         S_WAIT_GRANT: begin
            mem_req = 1'b1;
            if (mem_grant) begin
               mem_valid = 1'b1;
               w_next    = S_IDLE;
            end
         end
         S_WAIT_DRAIN: begin
            if (w_drained) begin
               if (w_last) begin
                  cntl_done = 1'b1;
                  w_next    = S_WAIT_DONE;
               end else begin
                  mem_valid  = 1'b1;
                  w_iter_inc = 1'b1;
                  w_flag_set = 1'b1;
                  w_next     = S_WAIT_STREAM;
               end
            end
         end
         S_WAIT_STREAM: begin
            if (stream_end) begin
               w_flag_clr = 1'b1;
               w_next     = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (vertex_done) begin
               task_complete = 1'b1;
               w_iter_clr    = 1'b1;
               w_next        = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Latched packet, configuration registers, replay bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_live         <= 1'b0;
         r_pkt          <= '0;
         r_iter         <= '0;
         r_flag         <= 1'b0;
         r_num_fv       <= '0;
         r_wb           <= '0;
         r_stream_begin <= 1'b0;
      end else begin
         r_live         <= 1'b1;
         r_stream_begin <= w_accept && (w_opcode == c_OP_NUM_FV);
         if (w_accept && !w_opcode[1]) begin
            r_pkt <= cmd_packet;
         end
         if (w_accept && (w_opcode == c_OP_NUM_FV)) begin
            r_num_fv <= cmd_packet[FV_W-1:0];
         end
         if (w_accept && (w_opcode == c_OP_WB)) begin
            r_wb <= cmd_packet[WB_W-1:0];
         end
         if (w_iter_inc) begin
            r_iter <= r_iter + c_IT_W'(1);
         end else if (w_iter_clr) begin
            r_iter <= '0;
         end
         if (w_flag_set) begin
            r_flag <= 1'b1;
         end else if (w_flag_clr) begin
            r_flag <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_param_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_cmd_decoder
// Description : Directed/randomized self-checking bench for param_cmd_decoder
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_cmd_decoder;

   localparam int PKT_W    = 32;
   localparam int NUM_PE   = 4;
   localparam int MAX_ITER = 4;
   localparam int MASK_LO  = 10;
   localparam int FV_W     = 5;
   localparam int WB_W     = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_valid;
   logic [PKT_W-1:0]  cmd_packet;
   logic              cmd_ready;
   logic              rs_valid;
   logic [PKT_W-3:0]  rs_packet;
   logic              rs_ready;
   logic              rs_empty;
   logic [NUM_PE-1:0] bank_busy;
   logic [NUM_PE-1:0] pe_idle;
   logic              mem_req;
   logic              mem_grant;
   logic              mem_valid;
   logic [PKT_W-1:0]  mem_packet;
   logic              stream_end;
   logic              vertex_done;
   logic              stream_begin;
   logic              replay_flag;
   logic [1:0]        replay_iter;
   logic [FV_W-1:0]   num_fv;
   logic [WB_W-1:0]   weights_boundary;
   logic              cntl_done;
   logic              task_complete;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int m_iter = 0;

   always #5 clk = ~clk;

   param_cmd_decoder #(
      .PKT_W(PKT_W), .NUM_PE(NUM_PE), .MAX_ITER(MAX_ITER),
      .MASK_LO(MASK_LO), .FV_W(FV_W), .WB_W(WB_W)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_packet(cmd_packet), .cmd_ready(cmd_ready),
      .rs_valid(rs_valid), .rs_packet(rs_packet), .rs_ready(rs_ready),
      .rs_empty(rs_empty), .bank_busy(bank_busy), .pe_idle(pe_idle),
      .mem_req(mem_req), .mem_grant(mem_grant), .mem_valid(mem_valid),
      .mem_packet(mem_packet), .stream_end(stream_end), .vertex_done(vertex_done),
      .stream_begin(stream_begin), .replay_flag(replay_flag),
      .replay_iter(replay_iter), .num_fv(num_fv),
      .weights_boundary(weights_boundary), .cntl_done(cntl_done),
      .task_complete(task_complete)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; pulses must never overlap
   task automatic step();
      #1;
      chk("excl", 32'(($countones({rs_valid, mem_valid, cntl_done, task_complete, stream_begin}) <= 1)), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_values();
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_rs_valid", 32'(rs_valid), 0);
      chk("rst_rs_packet", 32'(rs_packet), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_valid", 32'(mem_valid), 0);
      chk("rst_mem_packet", mem_packet, 0);
      chk("rst_stream_begin", 32'(stream_begin), 0);
      chk("rst_replay_flag", 32'(replay_flag), 0);
      chk("rst_replay_iter", 32'(replay_iter), 0);
      chk("rst_num_fv", 32'(num_fv), 0);
      chk("rst_wb", 32'(weights_boundary), 0);
      chk("rst_cntl_done", 32'(cntl_done), 0);
      chk("rst_task_complete", 32'(task_complete), 0);
   endtask

   // Present one command; leaves the bench in cycle N+1
   task automatic send(input logic [31:0] pkt);
      cmd_valid  = 1'b1;
      cmd_packet = pkt;
      #1;
      chk("send_cmd_ready", 32'(cmd_ready), 1);
      step();
      cmd_valid  = 1'b0;
      cmd_packet = 32'($urandom);
      #1;
   endtask

   // Task packet: route chosen by the mask bit of the current iteration
   task automatic do_task(input logic [3:0] msk, input int hold);
      logic [31:0] pkt;
      pkt = 32'($urandom);
      pkt[31:30] = 2'b00;
      pkt[MASK_LO +: 4] = msk;
      send(pkt);
      if (msk[m_iter]) begin
         for (int i = 0; i < hold; i++) begin
            chk("rs_valid_hold", 32'(rs_valid), 1);
            chk("rs_packet_hold", 32'(rs_packet), 32'(pkt[29:0]));
            chk("rs_cmd_ready", 32'(cmd_ready), 0);
            chk("rs_no_mem_req", 32'(mem_req), 0);
            step();
         end
         rs_ready = 1'b1;
         #1;
         chk("rs_valid_hs", 32'(rs_valid), 1);
         chk("rs_packet_hs", 32'(rs_packet), 32'(pkt[29:0]));
         step();
         rs_ready = 1'b0;
         #1;
         chk("rs_valid_after", 32'(rs_valid), 0);
         chk("rs_idle_ready", 32'(cmd_ready), 1);
      end else begin
         for (int i = 0; i < hold; i++) begin
            chk("mem_req_hold", 32'(mem_req), 1);
            chk("mem_valid_early", 32'(mem_valid), 0);
            chk("grant_cmd_ready", 32'(cmd_ready), 0);
            step();
         end
         mem_grant = 1'b1;
         #1;
         chk("mem_valid_grant", 32'(mem_valid), 1);
         chk("mem_packet_grant", mem_packet, pkt);
         step();
         mem_grant = 1'b0;
         #1;
         chk("mem_valid_once", 32'(mem_valid), 0);
         chk("mem_req_after", 32'(mem_req), 0);
         chk("grant_idle_ready", 32'(cmd_ready), 1);
      end
   endtask

   // Replay barrier; fixed_busy holds only bank 2 busy while undrained
   task automatic do_barrier(input int busy_cycles, input bit fixed_busy, input bit lose_end);
      logic [31:0] pkt;
      bit          drained;
      pkt = 32'($urandom);
      pkt[31:30] = 2'b01;
      send(pkt);
      for (int c = 0; c < 40; c++) begin
         stream_end = 1'b0;
         if (c >= busy_cycles) begin
            bank_busy = '0; rs_empty = 1'b1; pe_idle = '1;
         end else if (fixed_busy) begin
            bank_busy = 4'b0100; rs_empty = 1'b1; pe_idle = '1;
         end else begin
            bank_busy = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
            rs_empty  = 1'($urandom);
            pe_idle   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
         end
         drained = (bank_busy == 0) && rs_empty && (pe_idle == 4'hF);
         #1;
         if (!drained) begin
            chk("drain_wait_mem_valid", 32'(mem_valid), 0);
            chk("drain_wait_cntl_done", 32'(cntl_done), 0);
            chk("drain_wait_cmd_ready", 32'(cmd_ready), 0);
            step();
         end else if (m_iter < MAX_ITER - 1) begin
            stream_end = lose_end;
            #1;
            chk("replay_mem_valid", 32'(mem_valid), 1);
            chk("replay_mem_packet", mem_packet, pkt);
            chk("replay_no_cntl_done", 32'(cntl_done), 0);
            step();
            stream_end = 1'b0;
            m_iter++;
            chk("replay_iter_inc", 32'(replay_iter), 32'(m_iter));
            chk("replay_flag_set", 32'(replay_flag), 1);
            chk("replay_mem_valid_off", 32'(mem_valid), 0);
            chk("stream_wait_ready", 32'(cmd_ready), 0);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
               chk("stream_flag_hold", 32'(replay_flag), 1);
               step();
            end
            stream_end = 1'b1;
            step();
            stream_end = 1'b0;
            chk("stream_flag_clr", 32'(replay_flag), 0);
            chk("stream_idle_ready", 32'(cmd_ready), 1);
            break;
         end else begin
            chk("last_cntl_done", 32'(cntl_done), 1);
            chk("last_no_mem_valid", 32'(mem_valid), 0);
            step();
            chk("last_cntl_done_off", 32'(cntl_done), 0);
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
               chk("done_wait_ready", 32'(cmd_ready), 0);
               chk("done_wait_tc", 32'(task_complete), 0);
               step();
            end
            vertex_done = 1'b1;
            #1;
            chk("task_complete", 32'(task_complete), 1);
            step();
            vertex_done = 1'b0;
            m_iter = 0;
            chk("iter_wrap", 32'(replay_iter), 0);
            chk("done_idle_ready", 32'(cmd_ready), 1);
            break;
         end
      end
   endtask

   initial begin
      logic [31:0] pkt;
      reset = 1'b1; cmd_valid = 1'b0; cmd_packet = '0; rs_ready = 1'b0;
      rs_empty = 1'b1; bank_busy = '0; pe_idle = '1; mem_grant = 1'b0;
      stream_end = 1'b0; vertex_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_values();
      reset = 1'b0;
      step();
      chk("ready_after_release", 32'(cmd_ready), 1);

      // Stray grant in IDLE has no effect
      mem_grant = 1'b1;
      #1;
      chk("idle_grant_ignored", 32'(mem_valid), 0);
      step();
      mem_grant = 1'b0;

      do_task(4'b0001, 3);
      do_task(4'b0010, 5);
      for (int i = 0; i < 4; i++) do_task(4'($urandom), int'($urandom_range(0, 4)));

      do_barrier(6, 1'b1, 1'b1);

      // vertex_done outside WAIT_DONE is ignored
      vertex_done = 1'b1;
      #1;
      chk("vd_ignored_tc", 32'(task_complete), 0);
      step();
      vertex_done = 1'b0;
      chk("vd_ignored_iter", 32'(replay_iter), 32'(m_iter));

      for (int i = 0; i < 3; i++) do_task(4'($urandom), int'($urandom_range(0, 3)));
      do_barrier(int'($urandom_range(0, 8)), 1'b0, 1'($urandom));
      for (int i = 0; i < 3; i++) do_task(4'($urandom), int'($urandom_range(0, 3)));
      do_barrier(int'($urandom_range(0, 8)), 1'b0, 1'($urandom));
      do_barrier(int'($urandom_range(0, 8)), 1'b0, 1'b0);

      // Feature-vector count and stream begin
      pkt = 32'($urandom); pkt[31:30] = 2'b10; pkt[4:0] = 5'd9;
      send(pkt);
      chk("stream_begin_n1", 32'(stream_begin), 1);
      chk("num_fv", 32'(num_fv), 9);
      chk("fv_stays_idle", 32'(cmd_ready), 1);
      step();
      chk("stream_begin_once", 32'(stream_begin), 0);

      // Weights boundary then stream end
      pkt = 32'($urandom); pkt[31:30] = 2'b11; pkt[3:0] = 4'd7;
      send(pkt);
      chk("wb_latched", 32'(weights_boundary), 7);
      chk("wb_wait_ready", 32'(cmd_ready), 0);
      chk("wb_no_flag", 32'(replay_flag), 0);
      step();
      step();
      chk("wb_still_wait", 32'(cmd_ready), 0);
      stream_end = 1'b1;
      step();
      stream_end = 1'b0;
      chk("wb_idle_ready", 32'(cmd_ready), 1);
      chk("wb_hold", 32'(weights_boundary), 7);
      chk("fv_hold", 32'(num_fv), 9);

      // Reset asserted mid-handshake while requesting memory
      pkt = 32'($urandom); pkt[31:30] = 2'b00; pkt[MASK_LO +: 4] = 4'b1110;
      send(pkt);
      chk("pre_reset_mem_req", 32'(mem_req), 1);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_values();
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_iter = 0;
      step();
      chk("post_reset_ready", 32'(cmd_ready), 1);
      chk("post_reset_mem_req", 32'(mem_req), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
